// File: rtl/modk_timer_ctrl.sv
// rtl/modk_timer_ctrl.sv - prescaled mod-k counter sequencer with valid/ready configuration
module modk_timer_ctrl #(
  parameter int N         = 4,
  parameter int K_DEFAULT = 10,
  parameter int PRESCALE  = 50_000_000,
  parameter int PW        = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_k,
  input  logic         cfg_mode,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  output logic [N-1:0] count,
  output logic         tick,
  output logic         wrap,
  output logic         done,
  output logic         busy,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]  K_RST      = N'(K_DEFAULT);

  state_t        st, st_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [N-1:0]  count_nxt;
  logic [N-1:0]  k_reg;
  logic [N-1:0]  term;
  logic          mode;
  logic          tick_nxt, wrap_nxt;
  logic          at_term, presc_end;

  // k=0 wraps naturally to term=2^N-1 in N-bit arithmetic
  assign term      = k_reg - N'(1);
  assign at_term   = (count == term);
  assign presc_end = (presc == PRESC_LAST);

  assign cfg_ready = (st == IDLE) || (st == DONE);
  assign done      = (st == DONE);
  assign busy      = (st == RUN);
  assign state     = st;

  // Next state: the RUN-cycle update (prescaler step / tick) is applied first,
  // then the highest-priority command (clear > stop > start) acts on that result
  always_comb begin
    st_nxt    = st;
    count_nxt = count;
    presc_nxt = presc;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;

    if (st == RUN) begin
      if (presc_end) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
        wrap_nxt  = at_term;
        count_nxt = at_term ? '0 : count + 1'b1;
        if (mode && at_term) begin
          st_nxt = DONE;
        end
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end

    if (clear) begin
      st_nxt    = IDLE;
      count_nxt = '0;
      presc_nxt = '0;
    end else if (stop) begin
      if (st_nxt == RUN) begin
        st_nxt = PAUSE;
      end
    end else if (start) begin
      if ((st_nxt == IDLE) || (st_nxt == DONE)) begin
        st_nxt    = RUN;
        count_nxt = '0;
        presc_nxt = '0;
      end else if (st_nxt == PAUSE) begin
        st_nxt = RUN;
      end
    end
  end

  // Sequencer, counter, prescaler and pulse registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      count <= '0;
      presc <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      st    <= st_nxt;
      count <= count_nxt;
      presc <= presc_nxt;
      tick  <= tick_nxt;
      wrap  <= wrap_nxt;
    end
  end

  // Configuration latch; only open while the counter is idle or finished
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_reg <= K_RST;
      mode  <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      k_reg <= cfg_k;
      mode  <= cfg_mode;
    end
  end

endmodule
